// File: rtl/cmp_pkg.sv
// Shared encodings for blocks that consume the 4-bit magnitude comparator flags.
package cmp_pkg;

    // Debounced comparison state; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_BELOW   = 2'b01,
        ST_ABOVE   = 2'b10
    } state_e;

    // Direction of the current run of same-sense samples.
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_GT   = 2'b01,
        DIR_LT   = 2'b10
    } dir_e;

    // Wide enough for the largest legal debounce length (15).
    localparam int unsigned STREAK_W = 4;

    // True when exactly one of the three comparator flags is set.
    function automatic logic is_onehot3(input logic gt, input logic lt, input logic eq);
        logic [2:0] flags;
        flags = {gt, lt, eq};
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

endpackage

// File: rtl/cmp_streak_ctr.sv
// Tracks the direction and length of the current run of same-direction samples.
// hit is combinational: it flags the sample edge whose new count reaches DEBOUNCE.
module cmp_streak_ctr
    import cmp_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic gt,
    input  logic lt,
    input  logic clr,
    output dir_e dir,
    output logic hit
);

    localparam logic [STREAK_W-1:0] CntMax = STREAK_W'(DEBOUNCE);

    logic [STREAK_W-1:0] cnt_q, cnt_d;
    dir_e                dir_q, dir_d;

    // Next streak: extend same-direction runs, restart on a direction change,
    // clear on equality or a malformed sample.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (clr) begin
            cnt_d = '0;
            dir_d = DIR_NONE;
        end else if (valid) begin
            if (gt) begin
                if (dir_q == DIR_GT) begin
                    cnt_d = (cnt_q >= CntMax) ? CntMax : cnt_q + STREAK_W'(1);
                end else begin
                    cnt_d = STREAK_W'(1);
                    dir_d = DIR_GT;
                end
            end else if (lt) begin
                if (dir_q == DIR_LT) begin
                    cnt_d = (cnt_q >= CntMax) ? CntMax : cnt_q + STREAK_W'(1);
                end else begin
                    cnt_d = STREAK_W'(1);
                    dir_d = DIR_LT;
                end
            end else begin
                cnt_d = '0;
                dir_d = DIR_NONE;
            end
        end
    end

    // Streak registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dir_q <= DIR_NONE;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign dir = dir_d;
    assign hit = valid & ~clr & (gt | lt) & (cnt_d == CntMax);

endmodule

// File: rtl/cmp_hyst_monitor.sv
// Debounces comparator flags into a hysteretic ABOVE/BELOW state, pulses on
// entry to each state, counts BELOW<->ABOVE crossings and flags bad flag sets.
module cmp_hyst_monitor
    import cmp_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             agb,
    input  logic             alb,
    input  logic             aeb,
    input  logic             err_clr,
    output logic [1:0]       state,
    output logic             above,
    output logic             below,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cross_cnt,
    output logic             onehot_err
);

    state_e           state_q, state_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic onehot;
    logic bad_sample;
    dir_e dir;
    logic hit;

    assign onehot     = is_onehot3(agb, alb, aeb);
    assign bad_sample = in_valid & ~onehot;

    cmp_streak_ctr #(
        .DEBOUNCE(DEBOUNCE)
    ) u_streak (
        .clk  (clk),
        .rst  (rst),
        .valid(in_valid & onehot),
        .gt   (agb),
        .lt   (alb),
        .clr  (bad_sample),
        .dir  (dir),
        .hit  (hit)
    );

    // Next state, entry pulses, crossing count and sticky error.
    always_comb begin
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (hit && dir == DIR_GT && state_q != ST_ABOVE) begin
            state_d = ST_ABOVE;
            rise_d  = 1'b1;
            // Leaving UNKNOWN is not a crossing.
            if (state_q == ST_BELOW && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (hit && dir == DIR_LT && state_q != ST_BELOW) begin
            state_d = ST_BELOW;
            fall_d  = 1'b1;
            if (state_q == ST_ABOVE && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A new error wins over a simultaneous clear.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (bad_sample) begin
            err_d = 1'b1;
        end
    end

    // State FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNKNOWN;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign state      = state_q;
    assign above      = (state_q == ST_ABOVE);
    assign below      = (state_q == ST_BELOW);
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign cross_cnt  = cnt_q;
    assign onehot_err = err_q;

endmodule

// File: tb/tb_cmp_hyst_monitor.sv
// Directed bench for cmp_hyst_monitor: a DEBOUNCE=3/CNT_W=8 instance and a
// DEBOUNCE=1/CNT_W=2 instance share stimulus; each step selects which one to score.
module tb_cmp_hyst_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic agb = 1'b0;
    logic alb = 1'b0;
    logic aeb = 1'b0;
    logic err_clr = 1'b0;

    logic [1:0] a_state, b_state;
    logic       a_above, a_below, a_rise, a_fall, a_err;
    logic       b_above, b_below, b_rise, b_fall, b_err;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sel;
        logic [1:0] st;
        logic       r;
        logic       f;
        logic [7:0] c;
        logic       e;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cmp_hyst_monitor #(
        .DEBOUNCE(3),
        .CNT_W   (8)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .agb       (agb),
        .alb       (alb),
        .aeb       (aeb),
        .err_clr   (err_clr),
        .state     (a_state),
        .above     (a_above),
        .below     (a_below),
        .rise      (a_rise),
        .fall      (a_fall),
        .cross_cnt (a_cnt),
        .onehot_err(a_err)
    );

    cmp_hyst_monitor #(
        .DEBOUNCE(1),
        .CNT_W   (2)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .agb       (agb),
        .alb       (alb),
        .aeb       (aeb),
        .err_clr   (err_clr),
        .state     (b_state),
        .above     (b_above),
        .below     (b_below),
        .rise      (b_rise),
        .fall      (b_fall),
        .cross_cnt (b_cnt),
        .onehot_err(b_err)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output of the selected instance against one expectation.
    task automatic score(input exp_t x);
        logic [1:0] st;
        logic       ab, be, r, f, e;
        logic [7:0] c;
        if (x.sel) begin
            st = b_state; ab = b_above; be = b_below; r = b_rise; f = b_fall;
            c = {6'd0, b_cnt}; e = b_err;
        end else begin
            st = a_state; ab = a_above; be = a_below; r = a_rise; f = a_fall;
            c = a_cnt; e = a_err;
        end
        cmp({x.tag, ".state"}, {6'd0, st}, {6'd0, x.st});
        cmp({x.tag, ".above"}, {7'd0, ab}, {7'd0, x.st == 2'b10});
        cmp({x.tag, ".below"}, {7'd0, be}, {7'd0, x.st == 2'b01});
        cmp({x.tag, ".rise"}, {7'd0, r}, {7'd0, x.r});
        cmp({x.tag, ".fall"}, {7'd0, f}, {7'd0, x.f});
        cmp({x.tag, ".cnt"}, c, x.c);
        cmp({x.tag, ".err"}, {7'd0, e}, {7'd0, x.e});
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, score after the edge.
    task automatic step(input logic sel, input logic v, input logic g, input logic l,
                        input logic q, input logic clr, input logic [1:0] st,
                        input logic r, input logic f, input logic [7:0] c,
                        input logic e, input string tag);
        exp_t x;
        @(negedge clk);
        in_valid = v; agb = g; alb = l; aeb = q; err_clr = clr;
        x.sel = sel; x.st = st; x.r = r; x.f = f; x.c = c; x.e = e; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            cmp("sb_empty", 8'd1, 8'd0);
        end else begin
            score(sb.pop_front());
        end
    endtask

    // Assert reset between edges and check outputs clear without a clock.
    task automatic async_reset(input string tag);
        exp_t x;
        #2 rst = 1'b1;
        #1;
        x.st = 2'b00; x.r = 1'b0; x.f = 1'b0; x.c = 8'd0; x.e = 1'b0; x.tag = tag;
        x.sel = 1'b0;
        score(x);
        x.sel = 1'b1;
        x.tag = {tag, "_b"};
        score(x);
        @(negedge clk);
        in_valid = 1'b0; agb = 1'b0; alb = 1'b0; aeb = 1'b0; err_clr = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        #3;
        x.st = 2'b00; x.r = 1'b0; x.f = 1'b0; x.c = 8'd0; x.e = 1'b0;
        x.sel = 1'b0; x.tag = "reset_a";
        score(x);
        x.sel = 1'b1; x.tag = "reset_b";
        score(x);
        @(negedge clk);
        rst = 1'b0;

        // Three agb samples: ABOVE after the third, no crossing from UNKNOWN.
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 0, "up1");
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 0, "up2");
        step(0, 1, 1, 0, 0, 0, 2'b10, 1, 0, 8'd0, 0, "up3");
        step(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 8'd0, 0, "up_idle");
        step(0, 1, 1, 0, 0, 0, 2'b10, 0, 0, 8'd0, 0, "up_sat");

        // alb, alb, aeb, alb, alb, alb: equality restarts the streak.
        step(0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 8'd0, 0, "dn1");
        step(0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 8'd0, 0, "dn2");
        step(0, 1, 0, 0, 1, 0, 2'b10, 0, 0, 8'd0, 0, "dn_eq");
        step(0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 8'd0, 0, "dn4");
        step(0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 8'd0, 0, "dn5");
        step(0, 1, 0, 1, 0, 0, 2'b01, 0, 1, 8'd1, 0, "dn6");
        step(0, 1, 0, 1, 0, 0, 2'b01, 0, 0, 8'd1, 0, "dn_sat");
        step(0, 1, 1, 0, 0, 0, 2'b01, 0, 0, 8'd1, 0, "re1");
        step(0, 1, 1, 0, 0, 0, 2'b01, 0, 0, 8'd1, 0, "re2");
        step(0, 1, 1, 0, 0, 0, 2'b10, 1, 0, 8'd2, 0, "re3");

        // Idle gaps do not break a streak.
        async_reset("rst_gap");
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 0, "gap1");
        step(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 8'd0, 0, "gap_idle1");
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 0, "gap2");
        step(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 8'd0, 0, "gap_idle2");
        step(0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 8'd0, 0, "gap_idle3");
        step(0, 1, 1, 0, 0, 0, 2'b10, 1, 0, 8'd0, 0, "gap3");

        // Malformed sample clears the streak and sets the sticky error.
        async_reset("rst_err");
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 0, "err_pre1");
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 0, "err_pre2");
        step(0, 1, 1, 1, 0, 0, 2'b00, 0, 0, 8'd0, 1, "err_bad");
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 1, "err_post1");
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 1, "err_post2");
        step(0, 1, 1, 0, 0, 0, 2'b10, 1, 0, 8'd0, 1, "err_post3");
        step(0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 8'd0, 0, "err_clr");
        step(0, 0, 1, 1, 1, 0, 2'b10, 0, 0, 8'd0, 0, "err_invalid_bad");
        step(0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 8'd0, 0, "err_zero_flags_pre");
        step(0, 1, 0, 0, 0, 0, 2'b10, 0, 0, 8'd0, 1, "err_zero_flags");
        step(0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 8'd0, 0, "err_clr2");
        step(0, 1, 0, 1, 1, 1, 2'b10, 0, 0, 8'd0, 1, "err_set_wins");

        // Reset mid-streak clears the streak too.
        step(0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 8'd0, 1, "mid1");
        step(0, 1, 0, 1, 0, 0, 2'b10, 0, 0, 8'd0, 1, "mid2");
        async_reset("rst_mid");
        step(0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 8'd0, 0, "mid_after");
        step(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8'd0, 0, "mid_after_gt");

        // DEBOUNCE=1, CNT_W=2: every sample switches; count saturates at 3.
        async_reset("rst_b");
        step(1, 1, 0, 1, 0, 0, 2'b01, 0, 1, 8'd0, 0, "b1");
        step(1, 1, 1, 0, 0, 0, 2'b10, 1, 0, 8'd1, 0, "b2");
        step(1, 1, 0, 1, 0, 0, 2'b01, 0, 1, 8'd2, 0, "b3");
        step(1, 1, 1, 0, 0, 0, 2'b10, 1, 0, 8'd3, 0, "b4");
        step(1, 1, 0, 1, 0, 0, 2'b01, 0, 1, 8'd3, 0, "b5");
        step(1, 1, 1, 0, 0, 0, 2'b10, 1, 0, 8'd3, 0, "b6");
        step(1, 1, 0, 0, 1, 0, 2'b10, 0, 0, 8'd3, 0, "b_eq");
        step(1, 1, 1, 0, 0, 0, 2'b10, 0, 0, 8'd3, 0, "b_same");

        cmp("sb_drained", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
